arch_reg_dump: RTL and testbench

ARCH_REG_DUMP -- requirements
Module: arch_reg_dump

---
 rtl/arch_reg_dump.sv | 123 ++++++++++++
 tb/tb_arch_reg_dump.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arch_reg_dump.sv
`default_nettype none
// ============================================================================
// Module      : arch_reg_dump
// Description : Walks the rename map and PRF to stream out every architectural
//               register value over a valid/ready port once the ROB drains.
// Revision    : 1.0  initial release
// ============================================================================
module arch_reg_dump #(
    parameter int NUM_AREG = 32,
    parameter int PREG_W   = 7,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dump_req,
    input  logic              dump_abort,
    input  logic              rob_empty,
    output logic [4:0]        map_areg,
    input  logic [PREG_W-1:0] map_preg,
    output logic [PREG_W-1:0] prf_raddr,
    input  logic [DATA_W-1:0] prf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_areg,
    output logic [PREG_W-1:0] out_preg,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [4:0] c_LAST = 5'(NUM_AREG - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_QUIESCE = 3'd1,
        S_LOOKUP  = 3'd2,
        S_READ    = 3'd3,
        S_CAPTURE = 3'd4,
        S_SEND    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t              r_state;
    logic [4:0]          r_idx;
    logic [PREG_W-1:0]   r_preg_q;
    logic [4:0]          r_out_areg;
    logic [PREG_W-1:0]   r_out_preg;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_preg_q   <= '0;
            r_out_areg <= '0;
            r_out_preg <= '0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else if (dump_abort) begin
            // Abort outranks everything, including a simultaneous request in IDLE.
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (dump_req) begin
                        r_state <= S_QUIESCE;
                        r_idx   <= '0;
                    end
                end
                S_QUIESCE: begin
                    if (rob_empty) r_state <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    r_preg_q <= map_preg;
                    r_state  <= S_READ;
                end
                S_READ: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    // x0 is hardwired zero regardless of what its mapped PRF entry holds.
                    r_out_data <= (r_idx == 5'd0) ? '0 : prf_rdata;
                    r_out_areg <= r_idx;
                    r_out_preg <= r_preg_q;
                    r_out_last <= (r_idx == c_LAST);
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (r_out_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 5'd1;
                            r_state <= S_LOOKUP;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake and status outputs decode straight from the state register.
    assign out_valid = (r_state == S_SEND);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign map_areg  = (r_state == S_LOOKUP) ? r_idx : 5'd0;
    assign prf_raddr = (r_state == S_READ) ? r_preg_q : '0;

    assign out_areg  = r_out_areg;
    assign out_preg  = r_out_preg;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_arch_reg_dump.sv
`default_nettype none
// ============================================================================
// Module      : tb_arch_reg_dump
// Description : Directed self-checking bench for arch_reg_dump.
// Revision    : 1.0  initial release
// ============================================================================
module tb_arch_reg_dump;

    localparam int c_LIMIT = 600;

    logic        clk = 1'b0;
    logic        reset;
    logic        dump_req;
    logic        dump_abort;
    logic        rob_empty;
    logic [4:0]  map_areg;
    logic [6:0]  map_preg;
    logic [6:0]  prf_raddr;
    logic [31:0] prf_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_areg;
    logic [6:0]  out_preg;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_err    = 0;

    arch_reg_dump #(.NUM_AREG(32), .PREG_W(7), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .dump_req   (dump_req),
        .dump_abort (dump_abort),
        .rob_empty  (rob_empty),
        .map_areg   (map_areg),
        .map_preg   (map_preg),
        .prf_raddr  (prf_raddr),
        .prf_rdata  (prf_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_areg   (out_areg),
        .out_preg   (out_preg),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Rename map xN -> pN+32; PRF entry p holds p*3 with one cycle of read latency.
    always_comb map_preg = 7'(map_areg + 5'd0) + 7'd32;
    always @(posedge clk) prf_rdata <= 32'(prf_raddr) * 32'd3;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_areg"},  64'(out_areg),  64'd0);
        chk({tag, "_preg"},  64'(out_preg),  64'd0);
        chk({tag, "_data"},  64'(out_data),  64'd0);
        chk({tag, "_last"},  64'(out_last),  64'd0);
        chk({tag, "_busy"},  64'(busy),      64'd0);
        chk({tag, "_done"},  64'(done),      64'd0);
        chk({tag, "_map"},   64'(map_areg),  64'd0);
        chk({tag, "_raddr"}, 64'(prf_raddr), 64'd0);
    endtask

    // Issues dump_req and drives the consumer side. Returns early (in SEND of
    // stop_areg, before its handshake) when stop_areg >= 0, otherwise on done.
    task automatic do_dump(input int stop_areg, input int stall_areg, input int req_areg,
                           input int hold, output int n_words, output int n_done,
                           output int done_cyc);
        int  exp_a      = 0;
        int  cyc        = 0;
        int  stall_left = 5;
        bit  fin        = 1'b0;
        logic [31:0] exp_d;
        n_words  = 0;
        n_done   = 0;
        done_cyc = -1;
        out_ready = 1'b1;
        dump_req  = 1'b1;
        tick();
        cyc = 1;
        while (!fin && cyc < c_LIMIT) begin
            dump_req  = 1'b0;
            rob_empty = (cyc > hold);
            if (cyc <= hold) begin
                chk("quiesce_busy", 64'(busy), 64'd1);
                chk("quiesce_map",  64'(map_areg), 64'd0);
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                fin      = 1'b1;
            end else if (out_valid) begin
                exp_d = (exp_a == 0) ? 32'd0 : 32'((exp_a + 32) * 3);
                if (int'(out_areg) == stop_areg) begin
                    fin = 1'b1;
                end else if (int'(out_areg) == stall_areg && stall_left > 0) begin
                    out_ready = 1'b0;
                    chk("stall_areg", 64'(out_areg), 64'd7);
                    chk("stall_data", 64'(out_data), 64'd117);
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                    chk("word_areg",  64'(out_areg), 64'(exp_a));
                    chk("word_preg",  64'(out_preg), 64'(exp_a + 32));
                    chk("word_data",  64'(out_data), 64'(exp_d));
                    chk("word_last",  64'(out_last), 64'(exp_a == 31));
                    chk("word_raddr", 64'(prf_raddr), 64'd0);
                    exp_a++;
                    n_words++;
                end
                if (int'(out_areg) == req_areg) dump_req = 1'b1;
            end
            if (!fin) begin
                tick();
                cyc++;
            end
        end
        dump_req = 1'b0;
        chk("dump_timeout", 64'(cyc < c_LIMIT), 64'd1);
    endtask

    int nw, nd, dc;

    initial begin
        reset      = 1'b0;
        dump_req   = 1'b0;
        dump_abort = 1'b0;
        rob_empty  = 1'b1;
        out_ready  = 1'b1;
        #3;
        chk_all_zero("reset");
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk_all_zero("post_reset");

        // Abort and request together in IDLE: abort wins.
        dump_abort = 1'b1;
        dump_req   = 1'b1;
        tick();
        dump_abort = 1'b0;
        dump_req   = 1'b0;
        chk("abort_req_idle_busy", 64'(busy), 64'd0);
        tick();
        chk("abort_req_idle_busy2", 64'(busy), 64'd0);

        // Plain full dump.
        do_dump(-1, -1, -1, 0, nw, nd, dc);
        chk("basic_words", 64'(nw), 64'd32);
        chk("basic_done",  64'(nd), 64'd1);
        chk("basic_cycle", 64'(dc), 64'd130);
        tick();
        chk("basic_done_pulse", 64'(done), 64'd0);
        chk("basic_idle",       64'(busy), 64'd0);

        // ROB not empty for the first ten cycles.
        do_dump(-1, -1, -1, 10, nw, nd, dc);
        chk("quiesce_words", 64'(nw), 64'd32);
        chk("quiesce_cycle", 64'(dc), 64'd140);
        rob_empty = 1'b1;
        tick();

        // Back-pressure for five cycles on areg 7.
        do_dump(-1, 7, -1, 0, nw, nd, dc);
        chk("stall_words", 64'(nw), 64'd32);
        chk("stall_ndone", 64'(nd), 64'd1);
        chk("stall_cycle", 64'(dc), 64'd135);
        tick();

        // Abort while areg 12 is offered.
        do_dump(12, -1, -1, 0, nw, nd, dc);
        chk("abort_words_before", 64'(nw), 64'd12);
        chk("abort_valid_before", 64'(out_valid), 64'd1);
        dump_abort = 1'b1;
        tick();
        dump_abort = 1'b0;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_busy",  64'(busy),      64'd0);
        chk("abort_done",  64'(done),      64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_done", 64'(done | busy), 64'd0);
        end
        do_dump(-1, -1, -1, 0, nw, nd, dc);
        chk("abort_restart_words", 64'(nw), 64'd32);
        chk("abort_restart_cycle", 64'(dc), 64'd130);
        tick();

        // Repeated request while busy at areg 5 is ignored.
        do_dump(-1, -1, 5, 0, nw, nd, dc);
        chk("rereq_words", 64'(nw), 64'd32);
        chk("rereq_done",  64'(nd), 64'd1);
        chk("rereq_cycle", 64'(dc), 64'd130);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rereq_idle", 64'(busy | done), 64'd0);
        end

        // Asynchronous reset during CAPTURE of areg 20.
        do_dump(19, -1, -1, 0, nw, nd, dc);
        chk("rst_words_before", 64'(nw), 64'd19);
        tick();
        chk("rst_lookup_map", 64'(map_areg), 64'd20);
        tick();
        chk("rst_read_raddr", 64'(prf_raddr), 64'd52);
        tick();
        chk("rst_capture_busy", 64'(busy), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        reset = 1'b1;
        tick();
        chk("rst_idle_after", 64'(busy), 64'd0);
        do_dump(-1, -1, -1, 0, nw, nd, dc);
        chk("rst_restart_words", 64'(nw), 64'd32);
        chk("rst_restart_cycle", 64'(dc), 64'd130);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
